// File: rtl/sync_dec_pkg.sv
// Shared types and defaults for the registered decrementor / countdown block.
package sync_dec_pkg;

  localparam int DEC_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dec_state_t;

endpackage

// File: rtl/sync_decrementor_dec_core.sv
// Combinational subtract-one with borrow; the mirror image of the incrementor.
module dec_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  assign diff   = a - {{(WIDTH-1){1'b0}}, 1'b1};
  assign borrow = (a == '0);

endmodule

// File: rtl/sync_decrementor.sv
// Registered decrementor: single steps in IDLE, or a countdown to zero in RUN with a one-cycle DONE.
// Handshake: load/start/step are level-sampled on each rising edge; done and borrow_out are one-cycle pulses.
module sync_decrementor
  import sync_dec_pkg::*;
#(
  parameter int WIDTH    = DEC_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             start,
  input  logic             dec_en,
  output logic [WIDTH-1:0] count,
  output logic             borrow_out,
  output logic             busy,
  output logic             done,
  output dec_state_t       dbg_state
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  dec_state_t       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_borrow;

  dec_state_t       w_next_state;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_borrow;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;

  dec_core #(.WIDTH(WIDTH)) u_dec_core (
    .a      (r_count),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_borrow = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_next_count = load_val;
        end else if (start) begin
          // Starting from zero skips RUN entirely: nothing to count down.
          w_next_state = (r_count != '0) ? RUN : DONE;
        end else if (step) begin
          w_next_borrow = w_borrow;
          if (w_borrow && (SATURATE != 0)) w_next_count = '0;
          else                             w_next_count = w_diff;
        end
      end
      RUN: begin
        if (load) begin
          w_next_count = load_val;
          w_next_state = IDLE;
        end else if (dec_en) begin
          w_next_count = w_diff;
          if (r_count == ONE) w_next_state = DONE;
        end
      end
      DONE: begin
        if (load) w_next_count = load_val;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_borrow <= w_next_borrow;
    end
  end

  assign count      = r_count;
  assign borrow_out = r_borrow;
  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sync_decrementor.sv
// Directed bench for sync_decrementor: wrap (u_wrap) and saturating (u_sat) instances share stimulus.
module tb_sync_decrementor;
  import sync_dec_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] load_val;
  logic       step;
  logic       start;
  logic       dec_en;

  logic [3:0] w_count,  s_count;
  logic       w_borrow, s_borrow;
  logic       w_busy,   s_busy;
  logic       w_done,   s_done;
  dec_state_t w_state,  s_state;

  int total = 0;
  int bad   = 0;

  sync_decrementor #(.WIDTH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .step(step),
    .start(start), .dec_en(dec_en), .count(w_count), .borrow_out(w_borrow),
    .busy(w_busy), .done(w_done), .dbg_state(w_state)
  );

  sync_decrementor #(.WIDTH(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .step(step),
    .start(start), .dec_en(dec_en), .count(s_count), .borrow_out(s_borrow),
    .busy(s_busy), .done(s_done), .dbg_state(s_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive after the edge settles, sample #1 after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    load = 1'b0; load_val = 4'd0; step = 1'b0; start = 1'b0; dec_en = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_count", {28'd0, w_count}, 32'd0);
    check("rst_busy",  {31'd0, w_busy},  32'd0);
    check("rst_done",  {31'd0, w_done},  32'd0);
    check("rst_borrow",{31'd0, w_borrow},32'd0);
    check("rst_state", {30'd0, w_state}, {30'd0, IDLE});
    tick();
    rst_n = 1'b1;
    tick();

    // single steps
    do_load(4'b1011);
    check("load_1011", {28'd0, w_count}, 32'hb);
    do_step();
    check("step_1011",   {28'd0, w_count},  32'ha);
    check("step_1011_b", {31'd0, w_borrow}, 32'd0);
    do_load(4'b1000);
    do_step();
    check("step_1000",   {28'd0, w_count},  32'h7);
    do_load(4'b0001);
    do_step();
    check("step_0001",   {28'd0, w_count},  32'h0);
    check("step_0001_b", {31'd0, w_borrow}, 32'd0);

    // underflow from zero
    do_step();
    check("uf_wrap_count",  {28'd0, w_count},  32'hf);
    check("uf_wrap_borrow", {31'd0, w_borrow}, 32'd1);
    check("uf_sat_count",   {28'd0, s_count},  32'h0);
    check("uf_sat_borrow",  {31'd0, s_borrow}, 32'd1);
    tick();
    check("uf_wrap_pulse",  {31'd0, w_borrow}, 32'd0);
    check("uf_sat_pulse",   {31'd0, s_borrow}, 32'd0);
    check("uf_wrap_hold",   {28'd0, w_count},  32'hf);

    // countdown from 5, dec_en held high
    do_load(4'd5);
    start = 1'b1; dec_en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("cd_busy",  {31'd0, w_busy},  32'd1);
      check("cd_count", {28'd0, w_count}, 32'd5 - i);
      check("cd_nodone",{31'd0, w_done},  32'd0);
      tick();
    end
    check("cd_done",       {31'd0, w_done},  32'd1);
    check("cd_done_busy",  {31'd0, w_busy},  32'd0);
    check("cd_done_count", {28'd0, w_count}, 32'd0);
    check("cd_done_borrow",{31'd0, w_borrow},32'd0);
    tick();
    check("cd_done_pulse", {31'd0, w_done},  32'd0);
    check("cd_idle",       {30'd0, w_state}, {30'd0, IDLE});

    // countdown from 5 with a two-cycle pause: busy 7 cycles
    do_load(4'd5);
    start = 1'b1; dec_en = 1'b1;
    tick();
    start = 1'b0;
    check("pz_c5", {28'd0, w_count}, 32'd5);
    tick();
    check("pz_c4", {28'd0, w_count}, 32'd4);
    tick();
    check("pz_c3", {28'd0, w_count}, 32'd3);
    dec_en = 1'b0;
    tick();
    check("pz_hold1", {28'd0, w_count}, 32'd3);
    check("pz_busy1", {31'd0, w_busy},  32'd1);
    tick();
    check("pz_hold2", {28'd0, w_count}, 32'd3);
    dec_en = 1'b1;
    tick();
    check("pz_c2", {28'd0, w_count}, 32'd2);
    tick();
    check("pz_c1",   {28'd0, w_count}, 32'd1);
    check("pz_busy7",{31'd0, w_busy},  32'd1);
    tick();
    check("pz_done", {31'd0, w_done},  32'd1);
    check("pz_c0",   {28'd0, w_count}, 32'd0);
    dec_en = 1'b0;
    tick();

    // start with count==0 goes straight to DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("z_done",   {31'd0, w_done},   32'd1);
    check("z_busy",   {31'd0, w_busy},   32'd0);
    check("z_borrow", {31'd0, w_borrow}, 32'd0);
    check("z_count",  {28'd0, w_count},  32'd0);
    tick();
    check("z_idle",   {30'd0, w_state},  {30'd0, IDLE});

    // load beats start in IDLE
    load = 1'b1; load_val = 4'd3; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    check("pri_count", {28'd0, w_count}, 32'd3);
    check("pri_state", {30'd0, w_state}, {30'd0, IDLE});

    // load aborts RUN
    start = 1'b1; dec_en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ab_c2", {28'd0, w_count}, 32'd2);
    do_load(4'd12);
    check("ab_count", {28'd0, w_count}, 32'd12);
    check("ab_busy",  {31'd0, w_busy},  32'd0);
    check("ab_done",  {31'd0, w_done},  32'd0);
    tick();
    check("ab_done2", {31'd0, w_done},  32'd0);
    check("ab_hold",  {28'd0, w_count}, 32'd12);

    // async reset mid-countdown
    do_load(4'd9);
    start = 1'b1; dec_en = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mr_pre", {28'd0, w_count}, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("mr_count", {28'd0, w_count}, 32'd0);
    check("mr_busy",  {31'd0, w_busy},  32'd0);
    check("mr_done",  {31'd0, w_done},  32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_nodone", {31'd0, w_done}, 32'd0);
    end
    check("mr_state", {30'd0, w_state}, {30'd0, IDLE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
